mts_sysref_ctrl: RTL and testbench

- Supervises the synchronized PL SYSREF level in the pl_clk domain for multi-tile sync (MTS).
- Detects SYSREF rising edges, measures their period and declares lock after N consecutive in-tolerance periods.
- On software arm, emits exactly one aligned single-cycle user SYSREF pulse to the downstream ADC/DAC capture logic.
- Sits directly after the PL SYSREF CDC synchronizer; its configuration and status ports map to software registers.

---
 rtl/mts_sysref_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_mts_sysref_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mts_sysref_ctrl.sv
`default_nettype none
// ============================================================================
// mts_sysref_ctrl : SYSREF period supervisor, lock detector and single-shot
//                   aligned user SYSREF generator for multi-tile sync.
// Revision        : 1.0
// ============================================================================
module mts_sysref_ctrl #(
    parameter int CNT_W  = 16,
    parameter int LOCK_W = 4,
    parameter int ERR_W  = 16
) (
    input  logic              pl_clk,
    input  logic              pl_rstn,
    input  logic              sysref_sync,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_tol,
    input  logic [LOCK_W-1:0] cfg_lock_cnt,
    input  logic              arm_valid,
    output logic              arm_ready,
    input  logic              err_clr,
    output logic              sysref_edge,
    output logic              locked,
    output logic              armed,
    output logic              user_sysref,
    output logic              capture_done,
    output logic              capture_fail,
    output logic [CNT_W-1:0]  period_meas,
    output logic [ERR_W-1:0]  err_cnt
);

    typedef enum logic [1:0] {
        S_SEEK   = 2'd0,
        S_TRACK  = 2'd1,
        S_LOCKED = 2'd2,
        S_ARMED  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_sysref_q;
    logic              r_edge;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_to_done;
    logic [LOCK_W-1:0] r_good_cnt;
    logic [LOCK_W-1:0] w_good_nxt;
    logic              w_user_nxt;
    logic              w_fail_nxt;
    logic              w_done_nxt;
    logic              w_err_inc;
    logic [CNT_W:0]    w_cnt_ext;
    logic [CNT_W:0]    w_per_ext;
    logic [CNT_W:0]    w_limit;
    logic [CNT_W:0]    w_diff;
    logic              w_good;
    logic              w_bad_edge;
    logic              w_timeout;
    logic              w_arm_acc;
    logic [LOCK_W-1:0] w_lock_tgt;
    logic [LOCK_W:0]   w_good_inc;

    // One extra bit keeps period +/- tolerance free of wrap-around.
    assign w_cnt_ext  = {1'b0, r_cnt};
    assign w_per_ext  = {1'b0, cfg_period};
    assign w_limit    = w_per_ext + {1'b0, cfg_tol};
    assign w_diff     = (w_cnt_ext >= w_per_ext) ? (w_cnt_ext - w_per_ext)
                                                 : (w_per_ext - w_cnt_ext);
    assign w_good     = (w_diff <= {1'b0, cfg_tol});
    assign w_bad_edge = r_edge && !w_good && (r_state != S_SEEK);
    assign w_timeout  = !r_edge && !r_to_done && (r_state != S_SEEK) && (w_cnt_ext > w_limit);
    assign w_lock_tgt = (cfg_lock_cnt == '0) ? LOCK_W'(1) : cfg_lock_cnt;
    assign w_good_inc = {1'b0, r_good_cnt} + (LOCK_W+1)'(1);

    assign arm_ready  = (r_state == S_LOCKED) && !w_bad_edge && !w_timeout;
    assign w_arm_acc  = arm_valid && arm_ready;
    assign locked     = (r_state == S_LOCKED) || (r_state == S_ARMED);
    assign armed      = (r_state == S_ARMED);

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good_cnt;
        w_user_nxt  = 1'b0;
        w_fail_nxt  = 1'b0;
        w_err_inc   = 1'b0;
        w_done_nxt  = capture_done;
        case (r_state)
            S_SEEK: begin
                if (r_edge) begin
                    w_state_nxt = S_TRACK;
                    w_good_nxt  = '0;
                end
            end
            S_TRACK: begin
                if (r_edge) begin
                    if (w_good) begin
                        if (w_good_inc >= {1'b0, w_lock_tgt}) begin
                            w_state_nxt = S_LOCKED;
                            w_good_nxt  = '0;
                        end else begin
                            w_good_nxt = w_good_inc[LOCK_W-1:0];
                        end
                    end else begin
                        w_err_inc  = 1'b1;
                        w_good_nxt = '0;
                    end
                end else if (w_timeout) begin
                    w_err_inc   = 1'b1;
                    w_state_nxt = S_SEEK;
                end
            end
            S_LOCKED: begin
                // arm_ready already excludes a coincident bad edge or timeout.
                if (w_arm_acc) begin
                    w_state_nxt = S_ARMED;
                    w_done_nxt  = 1'b0;
                end else if (w_bad_edge) begin
                    w_err_inc   = 1'b1;
                    w_state_nxt = S_TRACK;
                    w_good_nxt  = '0;
                end else if (w_timeout) begin
                    w_err_inc   = 1'b1;
                    w_state_nxt = S_SEEK;
                end
            end
            S_ARMED: begin
                if (r_edge) begin
                    if (w_good) begin
                        w_user_nxt  = 1'b1;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_LOCKED;
                    end else begin
                        w_fail_nxt  = 1'b1;
                        w_err_inc   = 1'b1;
                        w_state_nxt = S_TRACK;
                        w_good_nxt  = '0;
                    end
                end else if (w_timeout) begin
                    w_fail_nxt  = 1'b1;
                    w_err_inc   = 1'b1;
                    w_state_nxt = S_SEEK;
                end
            end
            default: begin
                w_state_nxt = S_SEEK;
            end
        endcase
    end

    always_ff @(posedge pl_clk) begin
        if (!pl_rstn) begin
            r_state      <= S_SEEK;
            r_sysref_q   <= 1'b1;
            r_edge       <= 1'b0;
            r_cnt        <= '0;
            r_to_done    <= 1'b0;
            r_good_cnt   <= '0;
            sysref_edge  <= 1'b0;
            user_sysref  <= 1'b0;
            capture_fail <= 1'b0;
            capture_done <= 1'b0;
            period_meas  <= '0;
            err_cnt      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_sysref_q   <= sysref_sync;
            r_edge       <= sysref_sync & ~r_sysref_q;
            r_good_cnt   <= w_good_nxt;
            sysref_edge  <= r_edge;
            user_sysref  <= w_user_nxt;
            capture_fail <= w_fail_nxt;
            capture_done <= w_done_nxt;
            if (r_edge) begin
                r_cnt <= CNT_W'(1);
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_edge) begin
                r_to_done <= 1'b0;
            end else if (w_timeout) begin
                r_to_done <= 1'b1;
            end
            if (r_edge && (r_state != S_SEEK)) begin
                period_meas <= r_cnt;
            end
            if (err_clr) begin
                err_cnt <= '0;
            end else if (w_err_inc && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mts_sysref_ctrl.sv
`default_nettype none
// Scoreboard bench for mts_sysref_ctrl: expected output events are queued by
// the stimulus and popped by a monitor whenever an edge/user/fail pulse shows.
module tb_mts_sysref_ctrl;

    logic        clk;
    logic        rstn;
    logic        sysref_sync;
    logic [15:0] cfg_period;
    logic [15:0] cfg_tol;
    logic [3:0]  cfg_lock_cnt;
    logic        arm_valid;
    logic        arm_ready;
    logic        err_clr;
    logic        sysref_edge;
    logic        locked;
    logic        armed;
    logic        user_sysref;
    logic        capture_done;
    logic        capture_fail;
    logic [15:0] period_meas;
    logic [3:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        e;
        logic        u;
        logic        f;
        logic        lk;
        logic        ar;
        logic        pm_chk;
        logic [15:0] pm;
        logic [3:0]  err;
        int          id;
    } exp_t;

    exp_t sb_q[$];

    mts_sysref_ctrl #(.CNT_W(16), .LOCK_W(4), .ERR_W(4)) dut (
        .pl_clk       (clk),
        .pl_rstn      (rstn),
        .sysref_sync  (sysref_sync),
        .cfg_period   (cfg_period),
        .cfg_tol      (cfg_tol),
        .cfg_lock_cnt (cfg_lock_cnt),
        .arm_valid    (arm_valid),
        .arm_ready    (arm_ready),
        .err_clr      (err_clr),
        .sysref_edge  (sysref_edge),
        .locked       (locked),
        .armed        (armed),
        .user_sysref  (user_sysref),
        .capture_done (capture_done),
        .capture_fail (capture_fail),
        .period_meas  (period_meas),
        .err_cnt      (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic e, input logic u, input logic f, input logic lk,
                                input logic ar, input logic pm_chk, input logic [15:0] pm,
                                input logic [3:0] err, input int id);
        exp_t x;
        x.e = e; x.u = u; x.f = f; x.lk = lk; x.ar = ar;
        x.pm_chk = pm_chk; x.pm = pm; x.err = err; x.id = id;
        return x;
    endfunction

    // Monitor: every output pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t x;
        if (sysref_edge === 1'b1 || user_sysref === 1'b1 || capture_fail === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event t=%0t edge=%b user=%b fail=%b required none",
                         $time, sysref_edge, user_sysref, capture_fail);
            end else begin
                x = sb_q.pop_front();
                if ({sysref_edge, user_sysref, capture_fail, locked, armed} !== {x.e, x.u, x.f, x.lk, x.ar}
                    || (x.pm_chk && period_meas !== x.pm) || err_cnt !== x.err) begin
                    errors++;
                    $display("FAIL event_%0d t=%0t got e/u/f/lk/ar=%b%b%b%b%b pm=%0d err=%0d required %b%b%b%b%b pm=%0d(chk=%b) err=%0d",
                             x.id, $time, sysref_edge, user_sysref, capture_fail, locked, armed,
                             period_meas, err_cnt, x.e, x.u, x.f, x.lk, x.ar, x.pm, x.pm_chk, x.err);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // One SYSREF rising edge followed by a gap of p cycles to the next rise.
    // arm_at: -1 no arm, -2 arm held the whole call, else the cycle index.
    task automatic do_period(input int p, input int arm_at, input exp_t e);
        sb_q.push_back(e);
        for (int i = 0; i < p; i++) begin
            sysref_sync = (i < 4);
            arm_valid   = (arm_at == -2) || (i == arm_at);
            @(posedge clk); #1;
        end
        arm_valid = 1'b0;
    endtask

    task automatic timeout_round(input exp_t e, input int clr_at);
        sb_q.push_back(e);
        for (int i = 0; i < 80; i++) begin
            sysref_sync = (i < 4);
            err_clr     = (i == clr_at);
            @(posedge clk); #1;
        end
        err_clr = 1'b0;
    endtask

    initial begin
        int k_hit;
        int n_fail;
        rstn = 1'b0; sysref_sync = 1'b1; cfg_period = 16'd64; cfg_tol = 16'd1;
        cfg_lock_cnt = 4'd4; arm_valid = 1'b0; err_clr = 1'b0;
        idle(3);
        chk("reset_flags", 32'({sysref_edge, locked, armed, user_sysref, capture_done, capture_fail, arm_ready}), 0);
        chk("reset_period_meas", 32'(period_meas), 0);
        chk("reset_err_cnt", 32'(err_cnt), 0);
        rstn = 1'b1;
        idle(5);             // level high straight out of reset is not an edge
        sysref_sync = 1'b0;
        idle(5);

        // Lock acquisition
        do_period(64, -1, mk(1, 0, 0, 0, 0, 0, 16'd0,  4'd0, 1));
        do_period(64, -1, mk(1, 0, 0, 0, 0, 1, 16'd64, 4'd0, 2));
        do_period(64, -1, mk(1, 0, 0, 0, 0, 1, 16'd64, 4'd0, 3));
        do_period(64, -1, mk(1, 0, 0, 0, 0, 1, 16'd64, 4'd0, 4));
        do_period(64, -1, mk(1, 0, 0, 1, 0, 1, 16'd64, 4'd0, 5));
        chk("locked_after_lock", 32'(locked), 1);
        chk("arm_ready_locked", 32'(arm_ready), 1);

        // Capture
        do_period(64, 20, mk(1, 0, 0, 1, 0, 1, 16'd64, 4'd0, 6));
        chk("armed_after_arm", 32'(armed), 1);
        chk("arm_ready_in_armed", 32'(arm_ready), 0);
        chk("done_clear_while_armed", 32'(capture_done), 0);
        do_period(64, -1, mk(1, 1, 0, 1, 0, 1, 16'd64, 4'd0, 7));
        chk("capture_done_set", 32'(capture_done), 1);

        // Tolerance window
        do_period(63, -1, mk(1, 0, 0, 1, 0, 1, 16'd64, 4'd0, 8));
        do_period(65, -1, mk(1, 0, 0, 1, 0, 1, 16'd63, 4'd0, 9));
        do_period(66, -1, mk(1, 0, 0, 1, 0, 1, 16'd65, 4'd0, 10));
        do_period(64, -1, mk(1, 0, 0, 0, 0, 1, 16'd66, 4'd1, 11));
        do_period(64, -1, mk(1, 0, 0, 0, 0, 1, 16'd64, 4'd1, 12));
        do_period(64, -1, mk(1, 0, 0, 0, 0, 1, 16'd64, 4'd1, 13));
        do_period(64, -1, mk(1, 0, 0, 0, 0, 1, 16'd64, 4'd1, 14));
        do_period(64, -1, mk(1, 0, 0, 1, 0, 1, 16'd64, 4'd1, 15));
        chk("capture_done_sticky", 32'(capture_done), 1);

        // Arm gating: arm on a bad edge, then held while tracking
        do_period(10, -1, mk(1, 0, 0, 1, 0, 1, 16'd64, 4'd1, 16));
        do_period(64,  1, mk(1, 0, 0, 0, 0, 1, 16'd10, 4'd2, 17));
        do_period(64, -2, mk(1, 0, 0, 0, 0, 1, 16'd64, 4'd2, 18));
        do_period(64, -2, mk(1, 0, 0, 0, 0, 1, 16'd64, 4'd2, 19));
        do_period(64, -2, mk(1, 0, 0, 0, 0, 1, 16'd64, 4'd2, 20));
        chk("no_arm_while_unlocked", 32'(armed), 0);
        do_period(64, -1, mk(1, 0, 0, 1, 0, 1, 16'd64, 4'd2, 21));

        // Timeout while armed
        do_period(64, 20, mk(1, 0, 0, 1, 0, 1, 16'd64, 4'd2, 22));
        chk("armed_again", 32'(armed), 1);
        chk("done_cleared_by_arm", 32'(capture_done), 0);
        sb_q.push_back(mk(0, 0, 1, 0, 0, 1, 16'd64, 4'd3, 23));
        k_hit  = -1;
        n_fail = 0;
        for (int k = 64; k <= 80; k++) begin
            @(posedge clk); #1;
            if (capture_fail === 1'b1) begin
                n_fail++;
                if (k_hit < 0) k_hit = k;
            end
        end
        chk("timeout_fail_cycle", 32'(k_hit), 67);
        chk("timeout_fail_once", 32'(n_fail), 1);
        chk("timeout_err_cnt", 32'(err_cnt), 3);
        chk("timeout_unlocked", 32'({locked, armed}), 0);

        // Reset while armed
        do_period(64, -1, mk(1, 0, 0, 0, 0, 0, 16'd0,  4'd3, 24));
        do_period(64, -1, mk(1, 0, 0, 0, 0, 1, 16'd64, 4'd3, 25));
        do_period(64, -1, mk(1, 0, 0, 0, 0, 1, 16'd64, 4'd3, 26));
        do_period(64, -1, mk(1, 0, 0, 0, 0, 1, 16'd64, 4'd3, 27));
        do_period(64, -1, mk(1, 0, 0, 1, 0, 1, 16'd64, 4'd3, 28));
        do_period(64, 20, mk(1, 0, 0, 1, 0, 1, 16'd64, 4'd3, 29));
        chk("armed_before_reset", 32'(armed), 1);
        rstn = 1'b0;
        cfg_lock_cnt = 4'd0;
        idle(1);
        chk("reset_armed_flags", 32'({sysref_edge, locked, armed, user_sysref, capture_done, capture_fail, arm_ready}), 0);
        chk("reset_armed_err", 32'({period_meas, err_cnt}), 0);
        rstn = 1'b1;
        idle(4);

        // Lock count of zero behaves as one
        do_period(64, -1, mk(1, 0, 0, 0, 0, 0, 16'd0,  4'd0, 30));
        do_period(64, -1, mk(1, 0, 0, 1, 0, 1, 16'd64, 4'd0, 31));
        chk("lock_cnt0_locked", 32'(locked), 1);

        // Error counter saturation and clear priority
        idle(80);
        chk("timeout_in_locked_err", 32'(err_cnt), 1);
        chk("timeout_in_locked_state", 32'(locked), 0);
        for (int r = 1; r <= 15; r++) begin
            timeout_round(mk(1, 0, 0, 0, 0, 0, 16'd0, 4'(r), 100 + r), -1);
        end
        chk("err_cnt_saturated", 32'(err_cnt), 15);
        timeout_round(mk(1, 0, 0, 0, 0, 0, 16'd0, 4'd15, 116), 67);
        chk("err_clr_priority", 32'(err_cnt), 0);

        idle(10);
        chk("scoreboard_drain", 32'(sb_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_expired t=%0t required finish before limit", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
